// File: rtl/trb_mem_sched.sv
// Trace buffer memory scheduler.
// Sits between the tracer and a single-port synchronous trace RAM. Store
// and load requests are buffered one deep. A small FSM serialises them onto
// the RAM port, so only one access is outstanding at a time. The buffer is
// a circular FIFO over the RAM. In trace mode, a full buffer overwrites its
// oldest word. In stream mode, a full buffer back-pressures the tracer.
// In trace mode, a delayed trigger freezes capture.

package DTB_PKG;
  localparam int TRB_WIDTH = 32;
endpackage

module trb_mem_sched #(
  parameter int TRB_DEPTH = 256
) (
  input  logic                               FPGA_CLK_I,
  input  logic                               RST_I,
  input  logic                               MODE_I,
  input  logic                               STORE_I,
  input  logic [DTB_PKG::TRB_WIDTH-1:0]      DATA_I,
  output logic                               STORE_PERM_O,
  input  logic                               LOAD_REQUEST_I,
  output logic                               LOAD_GRANT_O,
  output logic [DTB_PKG::TRB_WIDTH-1:0]      DATA_O,
  input  logic                               TRG_DELAYED_I,
  output logic                               FROZEN_O,
  output logic [$clog2(TRB_DEPTH)-1:0]       TRG_ADDR_O,
  output logic                               OVERFLOW_O,
  output logic                               MEM_WE_O,
  output logic [$clog2(TRB_DEPTH)-1:0]       MEM_ADDR_O,
  output logic [DTB_PKG::TRB_WIDTH-1:0]      MEM_WDATA_O,
  input  logic [DTB_PKG::TRB_WIDTH-1:0]      MEM_RDATA_I
);

  localparam int W  = DTB_PKG::TRB_WIDTH;
  localparam int AW = $clog2(TRB_DEPTH);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(TRB_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR      = 2'd1;
  localparam logic [1:0] ST_RD      = 2'd2;
  localparam logic [1:0] ST_RD_WAIT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;

  logic [W-1:0]  store_buf;
  logic          store_pending;
  logic          load_pending;
  logic          overflow;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic          mode_q;
  logic          perm_en;
  logic          last_store;

  logic          frozen;
  logic [AW-1:0] trg_addr;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;

  logic          grant;
  logic [W-1:0]  data_out;

  logic          trace_mode;
  logic          frozen_eff;
  logic          full;
  logic          store_elig;
  logic          load_elig;
  logic          pick_store;
  logic          pick_load;
  logic          launch_wr;
  logic          launch_rd;
  logic          wr_done;
  logic          rd_done;

  // Eligibility and arbitration between the buffered store and load.
  // In stream mode a full buffer holds the store back rather than
  // overwriting unread data. The last-served bit only changes when both
  // requests compete, so the store is served first after reset.
  always_comb begin
    trace_mode = ~mode_q;
    frozen_eff = frozen & trace_mode;
    full       = (count == FULL_COUNT);
    store_elig = store_pending & (trace_mode | ~full);
    load_elig  = load_pending & (count != '0);
    pick_store = store_elig & (~load_elig | ~last_store);
    pick_load  = load_elig & ~pick_store;
    wr_done    = (state == ST_WR);
    rd_done    = (state == ST_RD_WAIT);
  end

  // Next-state logic. Each memory operation returns to IDLE before the
  // next one can start.
  always_comb begin
    state_next = state;
    launch_wr  = 1'b0;
    launch_rd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_store) begin
          state_next = ST_WR;
          launch_wr  = 1'b1;
        end else if (pick_load) begin
          state_next = ST_RD;
          launch_rd  = 1'b1;
        end
      end
      ST_WR:      state_next = ST_IDLE;
      ST_RD:      state_next = ST_RD_WAIT;
      ST_RD_WAIT: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // One-word store buffer. A pulse that finds the buffer full is lost and
  // sets the sticky overflow flag. Stores are discarded while frozen.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      store_buf     <= '0;
      store_pending <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (STORE_I && store_pending) begin
        overflow <= 1'b1;
      end
      if (wr_done) begin
        store_pending <= 1'b0;
      end else if (STORE_I && !store_pending && !frozen_eff) begin
        store_buf     <= DATA_I;
        store_pending <= 1'b1;
      end
    end
  end

  // Load request flag. Requests arriving while one is outstanding merge
  // into it, and the flag clears when the word is returned.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      load_pending <= 1'b0;
    end else if (rd_done) begin
      load_pending <= 1'b0;
    end else if (LOAD_REQUEST_I) begin
      load_pending <= 1'b1;
    end
  end

  // Circular buffer pointers and fill count. A write into a full buffer
  // can only happen in trace mode. It drops the oldest word by moving the
  // read pointer along with the write pointer.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (wr_done) begin
      wptr <= wptr + 1'b1;
      if (full) begin
        rptr <= rptr + 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end else if (rd_done) begin
      rptr  <= rptr + 1'b1;
      count <= count - 1'b1;
    end
  end

  // Registered memory port. The strobe and address are presented during
  // WR or RD. Write enable is high only for the WR cycle.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= launch_wr;
      if (launch_wr) begin
        mem_addr  <= wptr;
        mem_wdata <= store_buf;
      end else if (launch_rd) begin
        mem_addr <= rptr;
      end
    end
  end

  // Read return. Capture the RAM word in RD_WAIT and grant it one cycle
  // later. DATA_O holds that word until the next grant.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      grant    <= 1'b0;
      data_out <= '0;
    end else begin
      grant <= rd_done;
      if (rd_done) begin
        data_out <= MEM_RDATA_I;
      end
    end
  end

  // Freeze on the first delayed trigger in trace mode, recording the write
  // pointer. Only reset clears the freeze.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      frozen   <= 1'b0;
      trg_addr <= '0;
    end else if (!frozen && trace_mode && TRG_DELAYED_I) begin
      frozen   <= 1'b1;
      trg_addr <= wptr;
    end
  end

  // Housekeeping: mode is sampled only in IDLE. perm_en keeps the store
  // permission low through reset. The arbitration bit records who won
  // the last contended decision.
  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      mode_q     <= 1'b0;
      perm_en    <= 1'b0;
      last_store <= 1'b0;
    end else begin
      perm_en <= 1'b1;
      if (state == ST_IDLE) begin
        mode_q <= MODE_I;
      end
      if ((launch_wr || launch_rd) && store_elig && load_elig) begin
        last_store <= launch_wr;
      end
    end
  end

  assign STORE_PERM_O = perm_en & ~store_pending & ~frozen_eff & (trace_mode | ~full);
  assign LOAD_GRANT_O = grant;
  assign DATA_O       = data_out;
  assign FROZEN_O     = frozen;
  assign TRG_ADDR_O   = trg_addr;
  assign OVERFLOW_O   = overflow;
  assign MEM_WE_O     = mem_we;
  assign MEM_ADDR_O   = mem_addr;
  assign MEM_WDATA_O  = mem_wdata;

endmodule

// File: tb/tb_trb_mem_sched.sv
// Directed bench for trb_mem_sched with a four-word trace memory.
module tb_trb_mem_sched;

  localparam int W     = DTB_PKG::TRB_WIDTH;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          store_i;
  logic [W-1:0]  data_i;
  logic          perm;
  logic          load_req;
  logic          grant;
  logic [W-1:0]  data_o;
  logic          trg;
  logic          frozen;
  logic [AW-1:0] trg_addr;
  logic          overflow;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;

  logic [W-1:0]  mem [DEPTH];

  int            checks;
  int            errors;
  int            we_cyc;
  int            we_cnt;
  int            gnt_cyc;
  logic [AW-1:0] we_addr;
  logic [W-1:0]  we_data;
  logic [W-1:0]  gnt_data;

  trb_mem_sched #(.TRB_DEPTH(DEPTH)) dut (
    .FPGA_CLK_I     (clk),
    .RST_I          (rst),
    .MODE_I         (mode),
    .STORE_I        (store_i),
    .DATA_I         (data_i),
    .STORE_PERM_O   (perm),
    .LOAD_REQUEST_I (load_req),
    .LOAD_GRANT_O   (grant),
    .DATA_O         (data_o),
    .TRG_DELAYED_I  (trg),
    .FROZEN_O       (frozen),
    .TRG_ADDR_O     (trg_addr),
    .OVERFLOW_O     (overflow),
    .MEM_WE_O       (mem_we),
    .MEM_ADDR_O     (mem_addr),
    .MEM_WDATA_O    (mem_wdata),
    .MEM_RDATA_I    (mem_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse store and/or load in the current cycle (cycle 0), then run
  // ncyc cycles and record the first write and the first grant.
  task automatic applyStimulus(input logic st, input logic ld, input logic [W-1:0] d, input int ncyc);
    we_cyc   = -1;
    gnt_cyc  = -1;
    we_cnt   = 0;
    we_addr  = '0;
    we_data  = '0;
    gnt_data = '0;
    store_i  = st;
    load_req = ld;
    data_i   = d;
    for (int n = 1; n <= ncyc; n++) begin
      tick();
      if (n == 1) begin
        store_i  = 1'b0;
        load_req = 1'b0;
        data_i   = '0;
      end
      if (mem_we) begin
        we_cnt++;
        if (we_cyc < 0) begin
          we_cyc  = n;
          we_addr = mem_addr;
          we_data = mem_wdata;
        end
      end
      if (grant && gnt_cyc < 0) begin
        gnt_cyc  = n;
        gnt_data = data_o;
      end
    end
  endtask

  // Two cycles of reset, then one cycle out of reset.
  task automatic doReset();
    rst      = 1'b1;
    store_i  = 1'b0;
    load_req = 1'b0;
    data_i   = '0;
    trg      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    mode     = 1'b0;
    store_i  = 1'b0;
    load_req = 1'b0;
    data_i   = '0;
    trg      = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Outputs while reset is held.
    tick();
    tick();
    checkOutput("rst_perm",     64'(perm),      64'(0));
    checkOutput("rst_grant",    64'(grant),     64'(0));
    checkOutput("rst_data_o",   64'(data_o),    64'(0));
    checkOutput("rst_frozen",   64'(frozen),    64'(0));
    checkOutput("rst_trg_addr", 64'(trg_addr),  64'(0));
    checkOutput("rst_overflow", 64'(overflow),  64'(0));
    checkOutput("rst_mem_we",   64'(mem_we),    64'(0));
    checkOutput("rst_mem_addr", 64'(mem_addr),  64'(0));
    checkOutput("rst_mem_wdat", 64'(mem_wdata), 64'(0));
    rst = 1'b0;
    tick();
    checkOutput("perm_after_rst", 64'(perm), 64'(1));

    // Stream mode: fill, back-pressure, then one load frees space.
    $display("[TB] stream mode fill");
    mode = 1'b1;
    doReset();
    applyStimulus(1'b1, 1'b0, 32'hA, 3);
    checkOutput("st_wr_latency", 64'(we_cyc),  64'(2));
    checkOutput("st_wr_addr",    64'(we_addr), 64'(0));
    checkOutput("st_wr_data",    64'(we_data), 64'hA);
    applyStimulus(1'b1, 1'b0, 32'hB, 3);
    applyStimulus(1'b1, 1'b0, 32'hC, 3);
    applyStimulus(1'b1, 1'b0, 32'hD, 3);
    checkOutput("st_last_addr",  64'(we_addr), 64'(3));
    checkOutput("st_full_perm",  64'(perm),    64'(0));
    applyStimulus(1'b0, 1'b1, '0, 4);
    checkOutput("st_ld_latency", 64'(gnt_cyc),  64'(4));
    checkOutput("st_ld_data",    64'(gnt_data), 64'hA);
    checkOutput("st_perm_back",  64'(perm),     64'(1));

    // Trace mode: six stores into four words keep the newest four.
    $display("[TB] trace mode overwrite");
    mode = 1'b0;
    doReset();
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 1'b0, W'(i), 3);
    end
    checkOutput("tr_wr6_addr",  64'(we_addr), 64'(1));
    checkOutput("tr_full_perm", 64'(perm),    64'(1));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, '0, 5);
      checkOutput("tr_ld_data", 64'(gnt_data), 64'(3 + k));
    end
    applyStimulus(1'b0, 1'b1, '0, 10);
    checkOutput("tr_empty_nogrant", 64'(gnt_cyc), 64'(-1));

    // Simultaneous store and load: store first, then alternate to load.
    $display("[TB] arbitration");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h1, 3);
    applyStimulus(1'b1, 1'b0, 32'h2, 3);
    applyStimulus(1'b1, 1'b1, 32'h3, 10);
    checkOutput("arb1_we_cyc",  64'(we_cyc),   64'(2));
    checkOutput("arb1_gnt_cyc", 64'(gnt_cyc),  64'(6));
    checkOutput("arb1_data",    64'(gnt_data), 64'h1);
    applyStimulus(1'b1, 1'b1, 32'h4, 10);
    checkOutput("arb2_gnt_cyc", 64'(gnt_cyc),  64'(4));
    checkOutput("arb2_we_cyc",  64'(we_cyc),   64'(5));
    checkOutput("arb2_data",    64'(gnt_data), 64'h2);

    // Back-to-back store pulses: second is lost, overflow sticks.
    $display("[TB] overflow");
    doReset();
    store_i = 1'b1;
    data_i  = 32'h55;
    tick();
    data_i  = 32'h66;
    tick();
    store_i = 1'b0;
    data_i  = '0;
    checkOutput("ovf_set",     64'(overflow),  64'(1));
    checkOutput("ovf_we",      64'(mem_we),    64'(1));
    checkOutput("ovf_wdata",   64'(mem_wdata), 64'h55);
    applyStimulus(1'b0, 1'b0, '0, 6);
    checkOutput("ovf_no_2nd_wr", 64'(we_cnt),   64'(0));
    checkOutput("ovf_sticky",    64'(overflow), 64'(1));
    applyStimulus(1'b0, 1'b1, '0, 6);
    checkOutput("ovf_ld_data",   64'(gnt_data), 64'h55);
    doReset();
    checkOutput("ovf_cleared",   64'(overflow), 64'(0));

    // Freeze in trace mode with a store already buffered.
    $display("[TB] freeze");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h1, 3);
    applyStimulus(1'b1, 1'b0, 32'h2, 3);
    applyStimulus(1'b1, 1'b0, 32'h3, 3);
    store_i = 1'b1;
    data_i  = 32'h4;
    tick();
    store_i = 1'b0;
    data_i  = '0;
    trg     = 1'b1;
    tick();
    trg = 1'b0;
    checkOutput("frz_frozen",   64'(frozen),    64'(1));
    checkOutput("frz_trg_addr", 64'(trg_addr),  64'(3));
    checkOutput("frz_buf_we",   64'(mem_we),    64'(1));
    checkOutput("frz_buf_addr", 64'(mem_addr),  64'(3));
    checkOutput("frz_buf_data", 64'(mem_wdata), 64'h4);
    tick();
    checkOutput("frz_perm",     64'(perm),      64'(0));
    applyStimulus(1'b1, 1'b0, 32'h77, 6);
    checkOutput("frz_no_write", 64'(we_cnt),    64'(0));
    checkOutput("frz_perm_hold", 64'(perm),     64'(0));
    trg = 1'b1;
    tick();
    trg = 1'b0;
    tick();
    checkOutput("frz_addr_kept", 64'(trg_addr), 64'(3));

    // Reset during RD_WAIT aborts the load.
    $display("[TB] reset mid-read");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h11, 3);
    applyStimulus(1'b1, 1'b0, 32'h22, 3);
    applyStimulus(1'b0, 1'b1, '0, 5);
    checkOutput("rr_first_data", 64'(gnt_data), 64'h11);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick();
    checkOutput("rr_rd_addr", 64'(mem_addr), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rr_grant",   64'(grant),     64'(0));
    checkOutput("rr_data_o",  64'(data_o),    64'(0));
    checkOutput("rr_addr",    64'(mem_addr),  64'(0));
    checkOutput("rr_wdata",   64'(mem_wdata), 64'(0));
    checkOutput("rr_misc",    64'({perm, frozen, trg_addr, overflow, mem_we}), 64'(0));
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 6);
    checkOutput("rr_no_grant", 64'(gnt_cyc), 64'(-1));
    checkOutput("rr_perm",     64'(perm),    64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net in case the run stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/trb_mem_sched.md
TRB_MEM_SCHED -- requirements
Module: trb_mem_sched

Interface
REQ-001 SHALL use parameter TRB_DEPTH, 256, trace memory depth in words; power of two, at least 4.
REQ-002 SHALL take TRB_WIDTH from DTB_PKG as the memory word width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: FPGA_CLK_I in 1, RST_I in 1.
REQ-004 MODE_I  in  1  0 = trace mode, 1 = stream mode.
REQ-005 STORE_I  in  1  single-cycle store pulse from the tracer.
REQ-006 DATA_I  in  TRB_WIDTH  tracer word; valid only in the cycle STORE_I is high.
REQ-007 STORE_PERM_O  out  1  store permission to the tracer.
REQ-008 LOAD_REQUEST_I  in  1  single-cycle load request pulse from the tracer.
REQ-009 LOAD_GRANT_O  out  1  one-cycle pulse; DATA_O holds a new word.
REQ-010 DATA_O  out  TRB_WIDTH  last word read; held until the next grant.
REQ-011 TRG_DELAYED_I  in  1  delayed trigger event from the tracer.
REQ-012 FROZEN_O  out  1  trace capture frozen after the delayed trigger.
REQ-013 TRG_ADDR_O  out  $clog2(TRB_DEPTH)  write pointer captured at freeze.
REQ-014 OVERFLOW_O  out  1  sticky flag: a store pulse was lost.
REQ-015 MEM_WE_O  out  1  memory write enable.
REQ-016 MEM_ADDR_O  out  $clog2(TRB_DEPTH)  memory address.
REQ-017 MEM_WDATA_O  out  TRB_WIDTH  memory write data.
REQ-018 MEM_RDATA_I  in  TRB_WIDTH  memory read data; valid one cycle after address.

Function
REQ-019 SHALL latch DATA_I into a one-word store buffer on STORE_I when the buffer is empty, and set store_pending.
REQ-020 SHALL ignore STORE_I and set OVERFLOW_O when the store buffer is full.
REQ-021 SHALL latch LOAD_REQUEST_I into load_pending; a second request while pending SHALL merge.
REQ-022 SHALL run the FSM IDLE -> WR -> IDLE for stores and IDLE -> RD -> RD_WAIT -> IDLE for loads; exactly one memory operation is in flight at any time.
REQ-023 IDLE SHALL select WR if store_pending, and RD if load_pending and count > 0.
REQ-024 When both are eligible, IDLE SHALL alternate using a last-served bit; after reset, store wins.
REQ-025 WR SHALL drive MEM_WE_O=1, MEM_ADDR_O=wptr, MEM_WDATA_O=buffer. On exit it SHALL increment wptr (wrapping), clear store_pending, and increment count.
REQ-026 In trace mode, WR with count==TRB_DEPTH SHALL instead advance rptr and leave count unchanged (oldest word overwritten).
REQ-027 RD SHALL drive MEM_ADDR_O=rptr and MEM_WE_O=0.
REQ-028 RD_WAIT SHALL register MEM_RDATA_I into DATA_O, pulse LOAD_GRANT_O in the following cycle, increment rptr (wrapping), decrement count, and clear load_pending.
REQ-029 Outside WR, MEM_WE_O SHALL be 0.
REQ-030 Latency SHALL be: STORE_I at cycle 0 -> MEM_WE_O at cycle 2; LOAD_REQUEST_I at cycle 0 -> LOAD_GRANT_O at cycle 4, when idle and eligible.
REQ-031 A load request with count==0 SHALL stay pending until a store completes.
REQ-032 count SHALL be $clog2(TRB_DEPTH)+1 bits wide and SHALL never exceed TRB_DEPTH or fall below 0.
REQ-033 STORE_PERM_O SHALL be 1 only when the buffer is empty, not FROZEN_O, and (MODE_I=0 or count < TRB_DEPTH).
REQ-034 In trace mode, the first TRG_DELAYED_I high SHALL set FROZEN_O and capture TRG_ADDR_O=wptr.
REQ-035 A store already buffered when FROZEN_O sets SHALL still be written.
REQ-036 FROZEN_O SHALL be ignored in stream mode and SHALL be cleared only by reset.
REQ-037 MODE_I SHALL be sampled only in IDLE; pointers and count SHALL be kept across mode changes.

Reset
REQ-038 RST_I SHALL clear FSM to IDLE, wptr, rptr, count, pending flags, the buffer, and the last-served bit.
REQ-039 RST_I SHALL clear all outputs to 0: STORE_PERM_O, LOAD_GRANT_O, DATA_O, FROZEN_O, TRG_ADDR_O, OVERFLOW_O, MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O.
REQ-040 STORE_PERM_O SHALL rise in the first cycle after reset deasserts.
REQ-041 Reset mid-operation SHALL abort the operation without a write; memory contents are unspecified.

Verification
REQ-042 Stream mode, TRB_DEPTH=4: 4 stores (0xA..0xD) -> STORE_PERM_O=0; 1 load -> DATA_O=0xA with a LOAD_GRANT_O pulse, and STORE_PERM_O back to 1.
REQ-043 Trace mode, 6 stores 1..6 into depth 4, then 4 loads -> DATA_O sequence 3,4,5,6; count ends at 0.
REQ-044 STORE_I and LOAD_REQUEST_I in the same cycle with count=2 -> WR first, then RD; a repeat of the same cycle -> RD served first.
REQ-045 STORE_I on two consecutive cycles -> second dropped, OVERFLOW_O=1 and stays high until reset.
REQ-046 Trace mode, TRG_DELAYED_I rises with wptr=3 -> FROZEN_O=1, TRG_ADDR_O=3, STORE_PERM_O=0 from then on.
REQ-047 RST_I asserted during RD_WAIT -> no LOAD_GRANT_O pulse, all outputs 0 the next cycle.
